// File: rtl/dual_ram_pkg.sv
// Shared widths and the port-index type for the dual-requester RAM arbiter.
package dual_ram_pkg;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_idx_t;
endpackage

// File: rtl/dual_ram_pick.sv
// Combinational conflict detection and winner selection for two requesters.
module dual_ram_pick
    import dual_ram_pkg::*;
(
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  port_idx_t         ptr,
    output logic              gnt0,
    output logic              gnt1,
    output logic              conflict
);
    // Same-address read-read is harmless; any write on a shared address is not.
    assign conflict = req0 & req1 & (addr0 == addr1) & (we0 | we1);
    assign gnt0     = req0 & ~(conflict & (ptr == PORT1));
    assign gnt1     = req1 & ~(conflict & (ptr == PORT0));
endmodule

// File: rtl/dual_ram_arbiter.sv
// Two-requester front end for a dual-port RAM; requester 0 drives port 1, requester 1 port 2.
// Define DRAM_ARB_RR_EN for round-robin conflict resolution (default: port 0 always wins).
module dual_ram_arbiter
    import dual_ram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_we1,
    output logic              ram_we2,
    output logic [ADDR_W-1:0] ram_addr1,
    output logic [ADDR_W-1:0] ram_addr2,
    output logic [DATA_W-1:0] ram_din1,
    output logic [DATA_W-1:0] ram_din2,
    input  logic [DATA_W-1:0] ram_dout1,
    input  logic [DATA_W-1:0] ram_dout2,
    output logic [CNT_W-1:0]  conflict_cnt
);
    port_idx_t         ptr;
    logic              pick_gnt0;
    logic              pick_gnt1;
    logic              conflict;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [ADDR_W-1:0] addr1_q;
    logic [ADDR_W-1:0] addr2_q;
    logic [DATA_W-1:0] din1_q;
    logic [DATA_W-1:0] din2_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    dual_ram_pick u_pick (
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .ptr      (ptr),
        .gnt0     (pick_gnt0),
        .gnt1     (pick_gnt1),
        .conflict (conflict)
    );

`ifdef DRAM_ARB_RR_EN
    port_idx_t ptr_q;
    port_idx_t ptr_d;

    // The loser of a conflict is favoured next time; ordinary cycles leave it alone.
    always_comb begin
        ptr_d = ptr_q;
        if (conflict) begin
            ptr_d = (ptr_q == PORT0) ? PORT1 : PORT0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= PORT0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = PORT0;
`endif

    assign gnt0 = pick_gnt0 & rst_n;
    assign gnt1 = pick_gnt1 & rst_n;

    // Address/data lines park on the last granted access when idle.
    assign ram_we1   = gnt0 & we0;
    assign ram_we2   = gnt1 & we1;
    assign ram_addr1 = gnt0 ? addr0  : addr1_q;
    assign ram_addr2 = gnt1 ? addr1  : addr2_q;
    assign ram_din1  = gnt0 ? wdata0 : din1_q;
    assign ram_din2  = gnt1 ? wdata1 : din2_q;

    assign cnt_d = (conflict && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            addr1_q   <= '0;
            addr2_q   <= '0;
            din1_q    <= '0;
            din2_q    <= '0;
            cnt_q     <= '0;
        end else begin
            rvalid0_q <= gnt0 & ~we0;
            rvalid1_q <= gnt1 & ~we1;
            addr1_q   <= ram_addr1;
            addr2_q   <= ram_addr2;
            din1_q    <= ram_din1;
            din2_q    <= ram_din2;
            cnt_q     <= cnt_d;
        end
    end

    assign rvalid0      = rvalid0_q;
    assign rvalid1      = rvalid1_q;
    assign rdata0       = ram_dout1;
    assign rdata1       = ram_dout2;
    assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_dual_ram_arbiter.sv
// Scoreboard bench for dual_ram_arbiter with a registered-read dual-port RAM model.
module tb_dual_ram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [9:0]  addr0 = '0, addr1 = '0;
    logic [7:0]  wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0]  rdata0, rdata1;
    logic        ram_we1, ram_we2;
    logic [9:0]  ram_addr1, ram_addr2;
    logic [7:0]  ram_din1, ram_din2;
    logic [7:0]  ram_dout1, ram_dout2;
    logic [15:0] conflict_cnt;

    int n_vec = 0;
    int n_miss = 0;
    int n_cyc = 0;

    logic [7:0]  ram [0:1023];
    logic [7:0]  shadow [0:1023];
    logic [7:0]  q0 [$];
    logic [7:0]  q1 [$];
    logic        m_ptr = 1'b0;
    logic [15:0] m_cnt = '0;
    logic [9:0]  held_a1 = '0, held_a2 = '0;
    logic [7:0]  held_d1 = '0, held_d2 = '0;

    always #5 clk = ~clk;

    dual_ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_we1(ram_we1), .ram_we2(ram_we2),
        .ram_addr1(ram_addr1), .ram_addr2(ram_addr2),
        .ram_din1(ram_din1), .ram_din2(ram_din2),
        .ram_dout1(ram_dout1), .ram_dout2(ram_dout2),
        .conflict_cnt(conflict_cnt)
    );

    // Read-first dual-port RAM outside the arbiter.
    always @(posedge clk) begin
        if (ram_we1) ram[ram_addr1] <= ram_din1;
        if (ram_we2) ram[ram_addr2] <= ram_din2;
        ram_dout1 <= ram[ram_addr1];
        ram_dout2 <= ram[ram_addr2];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n_cyc);
        end
    endtask

    task automatic cycle(input logic r0, input logic w0, input logic [9:0] a0, input logic [7:0] d0,
                         input logic r1, input logic w1, input logic [9:0] a1, input logic [7:0] d1);
        logic cf, eg0, eg1;
        logic [7:0] e0, e1;
        @(negedge clk);
        rst_n = 1'b1;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        #1;
        n_cyc++;
        cf  = r0 & r1 & (a0 == a1) & (w0 | w1);
        eg0 = r0 & ~(cf & m_ptr);
        eg1 = r1 & ~(cf & ~m_ptr);
        check("gnt0", gnt0, eg0);
        check("gnt1", gnt1, eg1);
        check("ram_we1", ram_we1, eg0 & w0);
        check("ram_we2", ram_we2, eg1 & w1);
        if (eg0) begin held_a1 = a0; held_d1 = d0; end
        if (eg1) begin held_a2 = a1; held_d2 = d1; end
        check("ram_addr1", ram_addr1, held_a1);
        check("ram_din1", ram_din1, held_d1);
        check("ram_addr2", ram_addr2, held_a2);
        check("ram_din2", ram_din2, held_d2);
        if (eg0 && !w0) q0.push_back(shadow[a0]);
        if (eg1 && !w1) q1.push_back(shadow[a1]);
        if (eg0 && w0) shadow[a0] = d0;
        if (eg1 && w1) shadow[a1] = d1;
        if (cf) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`ifdef DRAM_ARB_RR_EN
            m_ptr = ~m_ptr;
`endif
        end
        $display("cyc %0d req=%b%b we=%b%b a0=%h a1=%h gnt=%b%b conflict=%b", n_cyc, r0, r1, w0, w1, a0, a1, gnt0, gnt1, cf);
        @(posedge clk);
        #1;
        check("rvalid0", rvalid0, eg0 & ~w0);
        check("rvalid1", rvalid1, eg1 & ~w1);
        if (eg0 && !w0 && q0.size() > 0) begin e0 = q0.pop_front(); check("rdata0", rdata0, e0); end
        if (eg1 && !w1 && q1.size() > 0) begin e1 = q1.pop_front(); check("rdata1", rdata1, e1); end
        check("conflict_cnt", conflict_cnt, m_cnt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'h3;
        req1 = 1'b1; we1 = 1'b0; addr1 = 10'h3;
        #1;
        n_cyc++;
        check("rst_gnt0", gnt0, 1'b0);
        check("rst_gnt1", gnt1, 1'b0);
        check("rst_ram_we1", ram_we1, 1'b0);
        check("rst_ram_we2", ram_we2, 1'b0);
        $display("cyc %0d reset", n_cyc);
        @(posedge clk);
        #1;
        check("rst_rvalid0", rvalid0, 1'b0);
        check("rst_rvalid1", rvalid1, 1'b0);
        check("rst_cnt", conflict_cnt, 16'h0);
        m_ptr = 1'b0; m_cnt = '0;
        held_a1 = '0; held_a2 = '0; held_d1 = '0; held_d2 = '0;
        q0.delete(); q1.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // Directed: write then read back on requester 0.
        cycle(1, 1, 10'h005, 8'hA5, 0, 0, 10'h000, 8'h00);
        cycle(1, 0, 10'h005, 8'h00, 0, 0, 10'h000, 8'h00);
        for (int i = 1; i < 4; i++)
            cycle(1, 1, 10'h010 + 10'(i), 8'h30 + 8'(i), 0, 0, 10'h000, 8'h00);
        // Two-cycle same-address write conflict, then read back.
        cycle(1, 1, 10'h010, 8'h11, 1, 1, 10'h010, 8'h22);
        cycle(1, 1, 10'h010, 8'h11, 1, 1, 10'h010, 8'h22);
        cycle(1, 0, 10'h010, 8'h00, 0, 0, 10'h000, 8'h00);
        // Read-read to the same address: both granted.
        cycle(1, 0, 10'h010, 8'h00, 1, 0, 10'h010, 8'h00);
        // Requester 1 alone, then idle (exercises held address/data).
        cycle(0, 0, 10'h000, 8'h00, 1, 1, 10'h012, 8'h5C);
        cycle(0, 0, 10'h3FF, 8'hFF, 0, 0, 10'h3FF, 8'hFF);
        cycle(0, 0, 10'h000, 8'h00, 1, 0, 10'h012, 8'h00);
        for (int i = 0; i < 40; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'h010 + 10'($urandom_range(0, 3)), 8'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'h010 + 10'($urandom_range(0, 3)), 8'($urandom));
        // Reset right after a granted read; next conflict must go to port 0.
        cycle(1, 0, 10'h005, 8'h00, 0, 0, 10'h000, 8'h00);
        do_reset();
        cycle(1, 1, 10'h020, 8'h77, 1, 1, 10'h020, 8'h88);
        cycle(1, 0, 10'h020, 8'h00, 0, 0, 10'h000, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
